// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/writeback control around the Booth multiplier.
// It accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU) over valid/ready.
// The operands and sign flags are driven straight to the multiplier on the
// accept cycle. After MUL_LAT cycles it picks the low or high product word and
// holds that word, with its tag, until writeback takes it.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_*                  request handshake, funct, tag and operands
//   kill                   flush of the in-flight operation (highest priority)
//   mul_req_*              operand strobe, operands and signedness to multiplier
//   mul_resp_result        64-bit product from the multiplier
//   resp_*                 result handshake, tag and selected 32-bit word
module mul_issue_ctrl #(
  parameter int MUL_LAT = 1,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_funct,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_in_1,
  input  logic [31:0]      req_in_2,
  input  logic             kill,
  output logic             mul_req_valid,
  output logic             mul_req_in_1_signed,
  output logic             mul_req_in_2_signed,
  output logic [31:0]      mul_req_in_1,
  output logic [31:0]      mul_req_in_2,
  input  logic [63:0]      mul_resp_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [TAG_W-1:0] resp_tag,
  output logic [31:0]      resp_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_CNT = 4'(MUL_LAT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       funct_q, funct_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             fire;

  // MUL keeps the low word; every high-half variant takes product[63:32]
  function automatic logic [31:0] sel_word(input logic [1:0] funct,
                                           input logic [63:0] prod);
    return (funct == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  // Issue: combinational handshake and operand/sign drive to the multiplier
  assign req_ready = ~kill & ((state_q == IDLE) | ((state_q == DONE) & resp_ready));
  assign fire      = req_valid & req_ready;

  assign mul_req_valid       = fire;
  assign mul_req_in_1        = req_in_1;
  assign mul_req_in_2        = req_in_2;
  assign mul_req_in_1_signed = (req_funct != 2'b11);
  assign mul_req_in_2_signed = ~req_funct[1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    funct_d      = funct_q;
    tag_d        = tag_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;

    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = BUSY;
          cnt_d   = LAT_CNT;
          tag_d   = req_tag;
          funct_d = req_funct;
        end
      end
      BUSY: begin
        if (kill) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_data_d  = sel_word(funct_q, mul_resp_result);
            resp_tag_d   = tag_q;
          end
        end
      end
      DONE: begin
        if (kill) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end else if (resp_ready) begin
          resp_valid_d = 1'b0;
          // accepting the result and a new request together keeps issue bubble-free
          if (fire) begin
            state_d = BUSY;
            cnt_d   = LAT_CNT;
            tag_d   = req_tag;
            funct_d = req_funct;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Writeback: state, counter and held result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      funct_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      funct_q      <= funct_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_tag   = resp_tag_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

  logic clk;
  logic reset;

  logic        req_valid   [2];
  logic        req_ready   [2];
  logic [1:0]  req_funct   [2];
  logic [4:0]  req_tag     [2];
  logic [31:0] req_in_1    [2];
  logic [31:0] req_in_2    [2];
  logic        kill        [2];
  logic        mreq_valid  [2];
  logic        s1          [2];
  logic        s2          [2];
  logic [31:0] m_in1       [2];
  logic [31:0] m_in2       [2];
  logic [63:0] mresp       [2];
  logic        resp_valid  [2];
  logic        resp_ready  [2];
  logic [4:0]  resp_tag    [2];
  logic [31:0] resp_data   [2];

  int checks;
  int failures;

  typedef struct {
    int          inst;
    logic [4:0]  tag;
    logic [31:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  mul_issue_ctrl #(.MUL_LAT(1), .TAG_W(5)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_funct(req_funct[0]),
    .req_tag(req_tag[0]), .req_in_1(req_in_1[0]), .req_in_2(req_in_2[0]),
    .kill(kill[0]), .mul_req_valid(mreq_valid[0]),
    .mul_req_in_1_signed(s1[0]), .mul_req_in_2_signed(s2[0]),
    .mul_req_in_1(m_in1[0]), .mul_req_in_2(m_in2[0]), .mul_resp_result(mresp[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_tag(resp_tag[0]), .resp_data(resp_data[0])
  );

  mul_issue_ctrl #(.MUL_LAT(3), .TAG_W(5)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_funct(req_funct[1]),
    .req_tag(req_tag[1]), .req_in_1(req_in_1[1]), .req_in_2(req_in_2[1]),
    .kill(kill[1]), .mul_req_valid(mreq_valid[1]),
    .mul_req_in_1_signed(s1[1]), .mul_req_in_2_signed(s2[1]),
    .mul_req_in_1(m_in1[1]), .mul_req_in_2(m_in2[1]), .mul_resp_result(mresp[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_tag(resp_tag[1]), .resp_data(resp_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mmodel(input logic [31:0] a, input logic [31:0] b,
                                         input logic sa, input logic sb);
    logic [63:0] ea, eb;
    ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Multiplier stand-in: product shows up MUL_LAT cycles after the strobe,
  // garbage before that.
  for (genvar g = 0; g < 2; g++) begin : g_mul
    localparam int L = (g == 0) ? 1 : 3;
    logic [63:0] prod;
    int          mcnt;
    always @(posedge clk) begin
      if (mreq_valid[g]) begin
        prod <= mmodel(m_in1[g], m_in2[g], s1[g], s2[g]);
        mcnt <= L - 1;
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
      end
    end
    assign mresp[g] = (mcnt == 0) ? prod : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, p;
    x = (f == 2'b11) ? longint'({32'b0, a}) : longint'($signed(a));
    y = f[1] ? longint'({32'b0, b}) : longint'($signed(b));
    p = x * y;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset && resp_valid[i] && resp_ready[i] && !kill[i]) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_resp", 64'(i), 64'hFF);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("sb_inst", 64'(i), 64'(e.inst));
          chk("sb_tag", 64'(resp_tag[i]), 64'(e.tag));
          chk("sb_data", 64'(resp_data[i]), 64'(e.data));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the fire edge.
  task automatic issue(input int sel, input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input bit push,
                       input logic [31:0] exp);
    req_valid[sel] = 1'b1;
    req_funct[sel] = f;
    req_in_1[sel]  = a;
    req_in_2[sel]  = b;
    req_tag[sel]   = tag;
    @(negedge clk);
    chk("req_ready", 64'(req_ready[sel]), 64'd1);
    chk("mul_req_valid", 64'(mreq_valid[sel]), 64'd1);
    chk("operand_pass", {m_in1[sel], m_in2[sel]}, {a, b});
    chk("sign_flags", 64'({s1[sel], s2[sel]}), 64'({f != 2'b11, ~f[1]}));
    if (push) sbq.push_back('{sel, tag, exp});
    @(posedge clk); #1;
    req_valid[sel] = 1'b0;
  endtask

  task automatic check_lat(input int sel);
    int lat;
    lat = (sel == 0) ? 1 : 3;
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      chk("lat_valid", 64'(resp_valid[sel]), 64'(k == lat));
      @(posedge clk); #1;
    end
  endtask

  task automatic post_reset_check(input int sel);
    @(negedge clk);
    chk("rst_valid", 64'(resp_valid[sel]), 64'd0);
    chk("rst_data", 64'(resp_data[sel]), 64'd0);
    chk("rst_tag", 64'(resp_tag[sel]), 64'd0);
    chk("rst_ready", 64'(req_ready[sel]), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    vecs[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[2] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4] = '{2'b00, 32'd6,         32'd7,         32'h0000_002A};
    vecs[5] = '{2'b01, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[6] = '{2'b11, 32'h8000_0000, 32'd2,         32'h0000_0001};
    vecs[7] = '{2'b10, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF};

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_funct[i] = '0; req_tag[i] = '0;
      req_in_1[i] = '0; req_in_2[i] = '0; kill[i] = 1'b0; resp_ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    post_reset_check(0);
    post_reset_check(1);
    @(posedge clk); #1;

    // table: each op issued alone with resp_ready held high
    for (int i = 0; i < 8; i++) begin
      issue(0, vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1, vecs[i].exp);
      check_lat(0);
    end

    // backpressure: result held for 5 cycles, then accept + new issue together
    resp_ready[0] = 1'b0;
    issue(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 1'b1, 32'hFFFF_FFFE);
    @(negedge clk);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_funct[0] = 2'b00; req_in_1[0] = 32'd6;
    req_in_2[0] = 32'd7; req_tag[0] = 5'd22;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 64'(resp_valid[0]), 64'd1);
      chk("bp_data", 64'(resp_data[0]), 64'hFFFF_FFFE);
      chk("bp_tag", 64'(resp_tag[0]), 64'd21);
      chk("bp_req_ready", 64'(req_ready[0]), 64'd0);
      chk("bp_no_fire", 64'(mreq_valid[0]), 64'd0);
      @(posedge clk); #1;
    end
    resp_ready[0] = 1'b1;
    issue(0, 2'b00, 32'd6, 32'd7, 5'd22, 1'b1, 32'h0000_002A);
    check_lat(0);

    // kill while BUSY
    issue(0, 2'b01, 32'd7, 32'hFFFF_FFFD, 5'd9, 1'b0, 32'h0);
    kill[0] = 1'b1;
    @(negedge clk);
    chk("kill_busy_ready", 64'(req_ready[0]), 64'd0);
    @(posedge clk); #1;
    kill[0] = 1'b0;
    @(negedge clk);
    chk("kill_busy_idle_ready", 64'(req_ready[0]), 64'd1);
    for (int c = 0; c < 4; c++) begin
      chk("kill_busy_no_resp", 64'(resp_valid[0]), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;

    // kill while DONE with resp_ready high
    issue(0, 2'b00, 32'd6, 32'd7, 5'd10, 1'b0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    kill[0] = 1'b1;
    @(negedge clk);
    chk("kill_done_valid_before", 64'(resp_valid[0]), 64'd1);
    chk("kill_done_ready", 64'(req_ready[0]), 64'd0);
    @(posedge clk); #1;
    kill[0] = 1'b0;
    @(negedge clk);
    chk("kill_done_dropped", 64'(resp_valid[0]), 64'd0);
    chk("kill_done_idle_ready", 64'(req_ready[0]), 64'd1);
    @(posedge clk); #1;

    // reset while BUSY
    issue(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 1'b0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    post_reset_check(0);
    @(posedge clk); #1;

    // reset while DONE
    resp_ready[0] = 1'b0;
    issue(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_done_valid_before", 64'(resp_valid[0]), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    post_reset_check(0);
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    issue(0, 2'b00, 32'd6, 32'd7, 5'd13, 1'b1, 32'h0000_002A);
    check_lat(0);

    // MUL_LAT=3 instance
    issue(1, 2'b00, 32'h0001_0000, 32'h0001_0000, 5'd1, 1'b1, 32'h0000_0000);
    check_lat(1);
    issue(1, 2'b11, 32'h0001_0000, 32'h0001_0000, 5'd2, 1'b1, 32'h0000_0001);
    check_lat(1);

    // back-to-back stream, one issue every MUL_LAT+1 cycles
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      req_valid[1] = 1'b1; req_funct[1] = 2'(i); req_in_1[1] = a;
      req_in_2[1] = b; req_tag[1] = 5'(16 + i);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!req_ready[1] && n < 20);
      chk("stream_ready", 64'(req_ready[1]), 64'd1);
      if (i > 0) chk("stream_gap", 64'(n), 64'd4);
      sbq.push_back('{1, 5'(16 + i), ref_mul(2'(i), a, b)});
      @(posedge clk); #1;
    end
    req_valid[1] = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Control and writeback stage that wraps the Booth multiplier.
- Accepts RISC-V M-extension multiply requests (MUL/MULH/MULHSU/MULHU) over a valid/ready handshake.
- Drives the multiplier's operand and sign inputs, waits a fixed latency, then selects the low or high 32 bits of the 64-bit product.
- Holds the selected word and its tag until the downstream writeback accepts it.

Parameters:
MUL_LAT, 1, cycles from multiplier operand capture (fire edge) until mul_resp_result is valid; legal range 1..15
TAG_W, 5, width of the request/response tag (destination register id)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_funct  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
req_tag  input  TAG_W  tag returned with the result
req_in_1  input  32  operand rs1
req_in_2  input  32  operand rs2
kill  input  1  flush: abort the in-flight operation
mul_req_valid  output  1  operand capture strobe to multiplier
mul_req_in_1_signed  output  1  rs1 signedness
mul_req_in_2_signed  output  1  rs2 signedness
mul_req_in_1  output  32  operand rs1 to multiplier
mul_req_in_2  output  32  operand rs2 to multiplier
mul_resp_result  input  64  product from multiplier
resp_valid  output  1  result available
resp_ready  input  1  downstream accepts result
resp_tag  output  TAG_W  tag of result
resp_data  output  32  selected result word

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, cnt=0, resp_valid=0, resp_data=0, resp_tag=0, held funct=0.
- Reset mid-operation discards all work. No response is produced for the aborted operation.

FSM states: IDLE, BUSY, DONE.
- req_ready = ~kill & ((state==IDLE) | (state==DONE & resp_ready)).
- fire = req_valid & req_ready.
- mul_req_valid = fire. This output is combinational.
- mul_req_in_1 and mul_req_in_2 pass req_in_1 and req_in_2 through combinationally.
- mul_req_in_1_signed = (req_funct != 2'b11).
- mul_req_in_2_signed = ~req_funct[1].

Transitions:
- On fire: state <= BUSY, cnt <= MUL_LAT. req_tag and req_funct are registered.
- In BUSY: cnt decrements each cycle.
- In BUSY with cnt==1: capture at that edge and go to DONE. resp_data <= (funct==00) ? mul_resp_result[31:0] : mul_resp_result[63:32]. resp_tag <= held tag. resp_valid <= 1.
- In DONE: resp_valid, resp_data and resp_tag stay stable until resp_ready.
- On resp_ready without fire: go to IDLE and clear resp_valid.
- On resp_ready with fire in the same cycle: go to BUSY. This gives back-to-back issue with no bubble on the request side.

Latency: fire at edge N gives resp_valid=1 in the cycle after edge N+MUL_LAT. With MUL_LAT=1, resp_valid is high 2 cycles after the request cycle.

Throughput: one operation per MUL_LAT+1 cycles when resp_ready is held high.

Kill:
- kill has priority over every other event.
- BUSY & kill: go to IDLE. No capture, no response.
- DONE & kill: resp_valid <= 0, go to IDLE. The result is discarded even if resp_ready is high in the same cycle.
- kill forces req_ready=0, so no operation starts in a kill cycle.

Holding rules:
- resp_valid never drops without resp_ready, kill, or reset.
- resp_data and resp_tag hold their values while resp_valid & ~resp_ready.

Width and arithmetic:
- No arithmetic is done in this block; it only selects product bits.
- The high word is always product[63:32]. Signedness is fully encoded by the two sign outputs.
- For MUL, the low word is independent of the sign flags.

Test Plan:
- MUL_LAT=1, MULHU rs1=rs2=0xFFFFFFFF, resp_ready=1 -> resp_data=0xFFFFFFFE, tag echoed, resp_valid 2 cycles after the request cycle, high for 1 cycle.
- Same operands with MUL / MULH / MULHSU -> resp_data 0x00000001 / 0x00000000 / 0xFFFFFFFF. Sign outputs are 11 / 11 / 10 respectively.
- Backpressure: result valid, resp_ready=0 for 5 cycles -> resp_valid, resp_data and resp_tag stable, req_ready=0. Then resp_ready=1 with req_valid=1 -> new request fires the same cycle, next result follows MUL_LAT+1 cycles later.
- kill during BUSY (MULH 7×-3) -> no resp_valid ever, state IDLE and req_ready=1 next cycle. kill in DONE with resp_ready=1 -> response dropped.
- reset asserted in BUSY and in DONE -> next cycle resp_valid=0, resp_data=0, resp_tag=0, req_ready=1. A subsequent MUL 6×7 returns 0x0000002A.
- MUL_LAT=3 build: MUL 0x00010000×0x00010000 -> resp_data 0x00000000 and MULHU returns 0x00000001, each valid exactly 4 cycles after fire. Back-to-back stream of 4 ops -> tags returned in order.
